// File: rtl/b_wrr_arb_if.sv
// b_wrr_arb_if: requester/channel-side signal bundle for the weighted round-robin arbiter.
//   master : requester side, drives req/last/weight/ready and observes the grant.
//   slave  : arbiter side, consumes req/last/weight/ready and drives gnt/gnt_id/busy.
// Signals:
//   req    [N]    per-requester beat valid
//   last   [N]    final beat of a packet, qualified by req
//   weight [N*WW] packet quota for requester i in bits [i*WW +: WW]
//   ready         downstream accepts a beat this cycle
//   gnt    [N]    registered one-hot grant, zero when idle
//   gnt_id [LOGN] index of the granted requester, valid while busy
//   busy          a grant is held
interface b_wrr_arb_if #(
    parameter int unsigned N  = 10,
    parameter int unsigned WW = 4
);
    localparam int unsigned LOGN = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*WW-1:0] weight;
    logic            ready;
    logic [N-1:0]    gnt;
    logic [LOGN-1:0] gnt_id;
    logic            busy;

    modport master (
        output req,
        output last,
        output weight,
        output ready,
        input  gnt,
        input  gnt_id,
        input  busy
    );

    modport slave (
        input  req,
        input  last,
        input  weight,
        input  ready,
        output gnt,
        output gnt_id,
        output busy
    );
endinterface

// File: rtl/b_wrr_arb.sv
// b_wrr_arb: weighted, packet-aware round-robin arbiter for N requesters sharing one channel.
// A registered one-hot grant is held for whole packets, up to max(weight,1) packets per grant,
// then rotates in circular order 0..N-1 starting after the last served requester.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : b_wrr_arb_if.slave (req, last, weight, ready in; gnt, gnt_id, busy out)
// Optional feature macro: B_WRR_ARB_FASTHANDOVER_EN
//   defined   : on release the next pending requester is granted in the same cycle
//   undefined : every release passes through one idle cycle
module b_wrr_arb #(
    parameter int unsigned N  = 10,
    parameter int unsigned WW = 4
) (
    input  logic         clk,
    input  logic         rst,
    b_wrr_arb_if.slave   bus
);
    localparam int unsigned LOGN = $clog2(N);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [LOGN-1:0] gnt_id_q, gnt_id_d;
    logic            busy_q, busy_d;
    logic [LOGN-1:0] last_ptr_q, last_ptr_d;
    logic [WW-1:0]   credit_q, credit_d;

    // Shared round-robin search: from last_ptr in IDLE, from the current owner (masked) in GRANT.
    logic [LOGN-1:0] srch_ptr;
    logic [N-1:0]    srch_req;
    logic            found;
    logic [LOGN-1:0] sel;
    logic [WW-1:0]   sel_raw_w;
    logic [WW-1:0]   sel_w;
    logic [N-1:0]    sel_onehot;

    always_comb begin
        int unsigned idx;
        srch_ptr = (state_q == StGrant) ? gnt_id_q : last_ptr_q;
        srch_req = bus.req;
        if (state_q == StGrant) begin
            srch_req[gnt_id_q] = 1'b0;
        end
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(srch_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && srch_req[LOGN'(idx)]) begin
                found = 1'b1;
                sel   = LOGN'(idx);
            end
        end
        sel_raw_w  = bus.weight[32'(sel) * WW +: WW];
        // A zero weight still earns one packet per grant.
        sel_w      = (sel_raw_w == '0) ? WW'(1) : sel_raw_w;
        sel_onehot = '0;
        sel_onehot[sel] = 1'b1;
    end

    logic cur_req;
    logic cur_last;
    logic cur_xfer;
    logic release_c;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        last_ptr_d = last_ptr_q;
        credit_d   = credit_q;
        cur_req    = bus.req[gnt_id_q];
        cur_last   = bus.last[gnt_id_q];
        cur_xfer   = cur_req & bus.ready;
        release_c  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d    = sel_onehot;
                    gnt_id_d = sel;
                    busy_d   = 1'b1;
                    credit_d = sel_w;
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                // A dropped request releases even mid-packet; the owner has nothing left to send.
                if (!cur_req) begin
                    release_c = 1'b1;
                end else if (cur_xfer && cur_last) begin
                    if (credit_q <= WW'(1)) begin
                        release_c = 1'b1;
                    end else begin
                        credit_d = credit_q - WW'(1);
                    end
                end

                if (release_c) begin
                    last_ptr_d = gnt_id_q;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
`ifdef B_WRR_ARB_FASTHANDOVER_EN
                    if (found) begin
                        gnt_d    = sel_onehot;
                        gnt_id_d = sel;
                        busy_d   = 1'b1;
                        credit_d = sel_w;
                        state_d  = StGrant;
                    end
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            last_ptr_q <= LOGN'(N - 1);
            credit_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            last_ptr_q <= last_ptr_d;
            credit_q   <= credit_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_b_wrr_arb.sv
// tb_b_wrr_arb: self-checking bench for b_wrr_arb (N=4, WW=4).
// Requesters are modelled as packet sources; every expected grant (owner and beats served)
// is queued when stimulus is set up and checked as the DUT opens and closes each grant.
module tb_b_wrr_arb;
    localparam int unsigned N  = 4;
    localparam int unsigned WW = 4;

    logic clk;
    logic rst;

    b_wrr_arb_if #(.N(N), .WW(WW)) bus ();

    b_wrr_arb #(.N(N), .WW(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int beats;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Requester model
    int pkts[N];
    int plen[N];
    int beat[N];
    int wt[N];

    // Per-cycle samples and grant tracking
    logic [N-1:0] s_gnt, s_req, prev_gnt;
    logic         s_busy;
    int           s_id, s_credit;
    int           cur_beats, exp_beats, gaps;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req[i]                = (pkts[i] > 0);
            bus.last[i]               = (beat[i] == plen[i] - 1);
            bus.weight[i*WW +: WW]    = WW'(wt[i]);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += pkts[i];
        return s;
    endfunction

    task automatic push(input int id, input int beats);
        exp_t e;
        e.id    = id;
        e.beats = beats;
        sb_q.push_back(e);
    endtask

    // One clock: sample at negedge, score grant changes, then advance the model after the edge.
    task automatic tick();
        logic [N-1:0] xfer;
        exp_t e;
        @(negedge clk);
        s_gnt    = bus.gnt;
        s_req    = bus.req;
        s_busy   = bus.busy;
        s_id     = int'(bus.gnt_id);
        s_credit = int'(dut.credit_q);
        if (s_gnt == '0 && s_req != '0) gaps++;
        if (s_gnt != prev_gnt) begin
            if (prev_gnt != '0) check("beats_per_grant", cur_beats, exp_beats);
            if (s_gnt != '0) begin
                check("onehot", int'($onehot(s_gnt)), 1);
                check("busy_on_grant", int'(s_busy), 1);
                if (sb_q.size() == 0) begin
                    check("unexpected_grant", s_id, -1);
                    exp_beats = 0;
                end else begin
                    e = sb_q.pop_front();
                    check("gnt_id", s_id, e.id);
                    check("gnt_vec", int'(s_gnt), 1 << e.id);
                    exp_beats = e.beats;
                end
            end
            cur_beats = 0;
        end
        prev_gnt  = s_gnt;
        xfer      = s_gnt & bus.req & {N{bus.ready}};
        cur_beats += $countones(xfer);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                beat[i]++;
                if (beat[i] >= plen[i]) begin
                    beat[i] = 0;
                    pkts[i]--;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            pkts[i] = 0;
            plen[i] = 1;
            beat[i] = 0;
            wt[i]   = 1;
        end
        bus.ready = 1'b1;
        drive();
        sb_q.delete();
        prev_gnt  = '0;
        cur_beats = 0;
        exp_beats = 0;
        gaps      = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (s_gnt != '0) seen = 1;
        end
        if (!seen) check("grant_timeout", 0, 1);
    endtask

    task automatic run_done(input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            if (pending() == 0 && s_gnt == '0) done = 1;
        end
        if (!done) check("run_timeout", 0, 1);
        check("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // Idle after reset, then 1-cycle request-to-grant latency.
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_gnt", int'(s_gnt), 0);
            check("idle_busy", int'(s_busy), 0);
        end
        pkts[0] = 1;
        push(0, 1);
        drive();
        tick();
        check("lat_before", int'(s_gnt), 0);
        tick();
        check("lat_after", int'(s_gnt), 1);
        run_done(50);

        // Unit weights, all requesting: rotation 0,1,2,3,0.
        do_reset();
        pkts[0] = 2; pkts[1] = 1; pkts[2] = 1; pkts[3] = 1;
        push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(0, 1);
        drive();
        run_done(100);
`ifdef B_WRR_ARB_FASTHANDOVER_EN
        check("bubbles", gaps, 1);
`else
        check("bubbles", gaps, 5);
`endif

        // weight[0]=3, weight[1]=1, 2-beat packets: 3 packets, 1 packet, then 0 again.
        do_reset();
        wt[0] = 3; wt[1] = 1;
        plen[0] = 2; plen[1] = 2;
        pkts[0] = 4; pkts[1] = 1;
        push(0, 6); push(1, 2); push(0, 2);
        drive();
        run_done(100);

        // ready low for 4 cycles mid-packet: grant and credit hold.
        do_reset();
        wt[1] = 2; plen[1] = 3; pkts[1] = 2;
        push(1, 6);
        drive();
        wait_grant(20);
        bus.ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_gnt", int'(s_gnt), 2);
            check("stall_credit", s_credit, 2);
        end
        bus.ready = 1'b1;
        run_done(100);

        // Asynchronous reset mid-packet while requester 2 owns the channel.
        do_reset();
        plen[2] = 4; pkts[2] = 1;
        push(2, 0);
        drive();
        wait_grant(20);
        check("pre_rst_gnt", int'(s_gnt), 4);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gnt", int'(bus.gnt), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        do_reset();
        pkts[0] = 1; pkts[2] = 1;
        push(0, 1); push(2, 1);
        drive();
        run_done(50);

        // weight 0 acts as 1: sole requester re-granted after every packet.
        do_reset();
        wt[3] = 0; pkts[3] = 3;
        push(3, 1); push(3, 1); push(3, 1);
        drive();
        wait_grant(20);
        check("w0_credit", s_credit, 1);
        run_done(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
